quote_scheduler: RTL and testbench

- Shares the single trading_logic datapath between NUM_STOCKS market-data streams.
- Holds one coalescing slot per stock. A newer update for a stock overwrites its pending one.
- Issues pending slots to the datapath in round-robin order, up to MAX_INFLIGHT outstanding.
- Tags each returned quote with its stock id through an in-order tag FIFO.

---
 rtl/quote_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_quote_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quote_scheduler.sv
// Shares one trading_logic datapath between NUM_STOCKS market-data streams. Each stock has a
// coalescing slot; pending slots issue round-robin, and returned quotes are tagged via an in-order FIFO.
module quote_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int NUM_STOCKS   = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_enable,
  input  logic                            i_md_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_md_stock_id,
  input  logic [DATA_WIDTH-1:0]           i_md_best_ask,
  input  logic [DATA_WIDTH-1:0]           i_md_best_bid,
  input  logic [FP_WORD_SIZE-1:0]         i_md_inventory,
  output logic                            o_tl_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]   o_tl_stock_id,
  output logic [DATA_WIDTH-1:0]           o_tl_best_ask,
  output logic [DATA_WIDTH-1:0]           o_tl_best_bid,
  output logic [FP_WORD_SIZE-1:0]         o_tl_inventory,
  input  logic                            i_tl_valid,
  input  logic [DATA_WIDTH-1:0]           i_tl_buy_price,
  input  logic [DATA_WIDTH-1:0]           i_tl_sell_price,
  output logic                            o_quote_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]   o_quote_stock_id,
  output logic [DATA_WIDTH-1:0]           o_buy_price,
  output logic [DATA_WIDTH-1:0]           o_sell_price,
  output logic [$clog2(MAX_INFLIGHT):0]   o_inflight,
  output logic [15:0]                     o_coalesce_cnt,
  output logic                            o_err_unexpected
);
  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [DATA_WIDTH-1:0]   ask_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   ask_d [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   bid_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   bid_d [NUM_STOCKS];
  logic [FP_WORD_SIZE-1:0] inv_q [NUM_STOCKS];
  logic [FP_WORD_SIZE-1:0] inv_d [NUM_STOCKS];
  logic [NUM_STOCKS-1:0]   valid_q, valid_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic [SW-1:0]           tag_q [MAX_INFLIGHT];
  logic [SW-1:0]           tag_d [MAX_INFLIGHT];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    tl_valid_q, tl_valid_d;
  logic [SW-1:0]           tl_id_q, tl_id_d;
  logic [DATA_WIDTH-1:0]   tl_ask_q, tl_ask_d, tl_bid_q, tl_bid_d;
  logic [FP_WORD_SIZE-1:0] tl_inv_q, tl_inv_d;
  logic                    quote_valid_q, quote_valid_d;
  logic [SW-1:0]           quote_id_q, quote_id_d;
  logic [DATA_WIDTH-1:0]   buy_q, buy_d, sell_q, sell_d;
  logic [15:0]             coal_q, coal_d;
  logic                    err_q, err_d;

  logic                    issue_s;
  logic                    pop_s;
  logic [SW-1:0]           grant_s;

  // Round-robin pick: lowest offset from ptr+1 wins, the pointer's own stock comes last.
  always_comb begin
    grant_s = ptr_q;
    issue_s = 1'b0;
    for (int k = NUM_STOCKS; k >= 1; k--) begin
      if (valid_q[ptr_q + SW'(k)]) begin
        grant_s = ptr_q + SW'(k);
        issue_s = 1'b1;
      end
    end
    if (!i_enable || (cnt_q >= MAX_CNT)) begin
      issue_s = 1'b0;
    end
  end

  // Next-state for slots, tag FIFO, issue port and quote port.
  always_comb begin
    ask_d         = ask_q;
    bid_d         = bid_q;
    inv_d         = inv_q;
    valid_d       = valid_q;
    ptr_d         = ptr_q;
    tag_d         = tag_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    tl_valid_d    = 1'b0;
    tl_id_d       = tl_id_q;
    tl_ask_d      = tl_ask_q;
    tl_bid_d      = tl_bid_q;
    tl_inv_d      = tl_inv_q;
    quote_valid_d = 1'b0;
    quote_id_d    = quote_id_q;
    buy_d         = buy_q;
    sell_d        = sell_q;
    coal_d        = coal_q;
    err_d         = err_q;
    pop_s         = i_tl_valid && (cnt_q != '0);

    if (issue_s) begin
      tl_valid_d      = 1'b1;
      tl_id_d         = grant_s;
      tl_ask_d        = ask_q[grant_s];
      tl_bid_d        = bid_q[grant_s];
      tl_inv_d        = inv_q[grant_s];
      valid_d[grant_s] = 1'b0;
      ptr_d           = grant_s;
      tag_d[wr_q]     = grant_s;
      wr_d            = wr_q + 1'b1;
    end

    if (pop_s) begin
      quote_valid_d = 1'b1;
      quote_id_d    = tag_q[rd_q];
      buy_d         = i_tl_buy_price;
      sell_d        = i_tl_sell_price;
      rd_d          = rd_q + 1'b1;
    end else if (i_tl_valid) begin
      err_d = 1'b1;
    end

    // A write landing on the stock being granted refills the slot without counting as a coalesce.
    if (i_md_valid) begin
      if (valid_q[i_md_stock_id] && !(issue_s && (grant_s == i_md_stock_id)) &&
          (coal_q != 16'hFFFF)) begin
        coal_d = coal_q + 16'd1;
      end
      ask_d[i_md_stock_id]   = i_md_best_ask;
      bid_d[i_md_stock_id]   = i_md_best_bid;
      inv_d[i_md_stock_id]   = i_md_inventory;
      valid_d[i_md_stock_id] = 1'b1;
    end

    case ({issue_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ask_q[s] <= '0;
        bid_q[s] <= '0;
        inv_q[s] <= '0;
      end
      for (int t = 0; t < MAX_INFLIGHT; t++) begin
        tag_q[t] <= '0;
      end
      valid_q       <= '0;
      ptr_q         <= SW'(NUM_STOCKS - 1);
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      tl_valid_q    <= 1'b0;
      tl_id_q       <= '0;
      tl_ask_q      <= '0;
      tl_bid_q      <= '0;
      tl_inv_q      <= '0;
      quote_valid_q <= 1'b0;
      quote_id_q    <= '0;
      buy_q         <= '0;
      sell_q        <= '0;
      coal_q        <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      ask_q         <= ask_d;
      bid_q         <= bid_d;
      inv_q         <= inv_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      ptr_q         <= ptr_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      tl_valid_q    <= tl_valid_d;
      tl_id_q       <= tl_id_d;
      tl_ask_q      <= tl_ask_d;
      tl_bid_q      <= tl_bid_d;
      tl_inv_q      <= tl_inv_d;
      quote_valid_q <= quote_valid_d;
      quote_id_q    <= quote_id_d;
      buy_q         <= buy_d;
      sell_q        <= sell_d;
      coal_q        <= coal_d;
      err_q         <= err_d;
    end
  end

  assign o_tl_valid       = tl_valid_q;
  assign o_tl_stock_id    = tl_id_q;
  assign o_tl_best_ask    = tl_ask_q;
  assign o_tl_best_bid    = tl_bid_q;
  assign o_tl_inventory   = tl_inv_q;
  assign o_quote_valid    = quote_valid_q;
  assign o_quote_stock_id = quote_id_q;
  assign o_buy_price      = buy_q;
  assign o_sell_price     = sell_q;
  assign o_inflight       = cnt_q;
  assign o_coalesce_cnt   = coal_q;
  assign o_err_unexpected = err_q;

endmodule

// File: tb/tb_quote_scheduler.sv
// Bench for quote_scheduler: a directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a queue-based reference model with a fixed-latency responder.
module tb_quote_scheduler;
  localparam int NS  = 4;
  localparam int MI  = 8;
  localparam int LAT = 5;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_md_valid = 1'b0;
  logic [1:0]  i_md_stock_id = 2'd0;
  logic [31:0] i_md_best_ask = 32'd0;
  logic [31:0] i_md_best_bid = 32'd0;
  logic [63:0] i_md_inventory = 64'd0;
  logic        i_tl_valid = 1'b0;
  logic [31:0] i_tl_buy_price = 32'd0;
  logic [31:0] i_tl_sell_price = 32'd0;
  logic        o_tl_valid;
  logic [1:0]  o_tl_stock_id;
  logic [31:0] o_tl_best_ask, o_tl_best_bid;
  logic [63:0] o_tl_inventory;
  logic        o_quote_valid;
  logic [1:0]  o_quote_stock_id;
  logic [31:0] o_buy_price, o_sell_price;
  logic [3:0]  o_inflight;
  logic [15:0] o_coalesce_cnt;
  logic        o_err_unexpected;

  always #5 i_clk = ~i_clk;

  quote_scheduler dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_md_valid(i_md_valid), .i_md_stock_id(i_md_stock_id),
    .i_md_best_ask(i_md_best_ask), .i_md_best_bid(i_md_best_bid), .i_md_inventory(i_md_inventory),
    .o_tl_valid(o_tl_valid), .o_tl_stock_id(o_tl_stock_id), .o_tl_best_ask(o_tl_best_ask),
    .o_tl_best_bid(o_tl_best_bid), .o_tl_inventory(o_tl_inventory),
    .i_tl_valid(i_tl_valid), .i_tl_buy_price(i_tl_buy_price), .i_tl_sell_price(i_tl_sell_price),
    .o_quote_valid(o_quote_valid), .o_quote_stock_id(o_quote_stock_id),
    .o_buy_price(o_buy_price), .o_sell_price(o_sell_price), .o_inflight(o_inflight),
    .o_coalesce_cnt(o_coalesce_cnt), .o_err_unexpected(o_err_unexpected)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: per-stock pending slots, a round-robin pointer and a queue of outstanding ids.
  logic [31:0] m_ask [NS];
  logic [31:0] m_bid [NS];
  logic [63:0] m_inv [NS];
  bit          m_v   [NS];
  int          m_rr;
  int          m_tags[$];
  logic        e_tlv, e_qv, e_err;
  logic [1:0]  e_tlid, e_qid;
  logic [31:0] e_tlask, e_tlbid, e_buy, e_sell;
  logic [63:0] e_tlinv;
  logic [15:0] e_coal;

  typedef struct { logic [31:0] ask; logic [31:0] bid; int due; } rsp_t;
  rsp_t rq[$];
  bit   auto_rsp = 1'b0;
  int   issued[$];

  typedef struct {
    int md_v; int id; int ask; int bid; int tlv; int buy; int sell;
    int e_tlv; int e_tlid; int e_tlask; int e_tlbid;
    int e_qv; int e_qid; int e_buy; int e_sell; int e_infl;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_ask[s] = 32'd0; m_bid[s] = 32'd0; m_inv[s] = 64'd0; m_v[s] = 1'b0;
    end
    m_rr = NS - 1;
    m_tags.delete();
    rq.delete();
    e_tlv = 1'b0; e_qv = 1'b0; e_err = 1'b0; e_tlid = 2'd0; e_qid = 2'd0;
    e_tlask = 32'd0; e_tlbid = 32'd0; e_tlinv = 64'd0; e_buy = 32'd0; e_sell = 32'd0;
    e_coal = 16'd0;
  endtask

  task automatic model_step();
    int g = -1;
    if (i_enable && m_tags.size() < MI) begin
      for (int k = 1; k <= NS; k++) begin
        if (g < 0 && m_v[(m_rr + k) % NS]) g = (m_rr + k) % NS;
      end
    end
    e_tlv = 1'b0;
    e_qv  = 1'b0;
    if (i_tl_valid) begin
      if (m_tags.size() > 0) begin
        e_qv = 1'b1; e_qid = 2'(m_tags.pop_front()); e_buy = i_tl_buy_price; e_sell = i_tl_sell_price;
      end else begin
        e_err = 1'b1;
      end
    end
    if (g >= 0) begin
      e_tlv = 1'b1; e_tlid = 2'(g); e_tlask = m_ask[g]; e_tlbid = m_bid[g]; e_tlinv = m_inv[g];
      m_v[g] = 1'b0;
      m_rr = g;
      m_tags.push_back(g);
      rq.push_back('{m_ask[g], m_bid[g], cyc + LAT});
    end
    if (i_md_valid) begin
      int id = int'(i_md_stock_id);
      if (m_v[id] && e_coal != 16'hFFFF) e_coal = e_coal + 16'd1;
      m_ask[id] = i_md_best_ask; m_bid[id] = i_md_best_bid; m_inv[id] = i_md_inventory; m_v[id] = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("tl_valid", 64'(o_tl_valid), 64'(e_tlv));
    chk("tl_stock_id", 64'(o_tl_stock_id), 64'(e_tlid));
    chk("tl_best_ask", 64'(o_tl_best_ask), 64'(e_tlask));
    chk("tl_best_bid", 64'(o_tl_best_bid), 64'(e_tlbid));
    chk("tl_inventory", o_tl_inventory, e_tlinv);
    chk("quote_valid", 64'(o_quote_valid), 64'(e_qv));
    chk("quote_stock_id", 64'(o_quote_stock_id), 64'(e_qid));
    chk("buy_price", 64'(o_buy_price), 64'(e_buy));
    chk("sell_price", 64'(o_sell_price), 64'(e_sell));
    chk("inflight", 64'(o_inflight), 64'(m_tags.size()));
    chk("coalesce_cnt", 64'(o_coalesce_cnt), 64'(e_coal));
    chk("err_unexpected", 64'(o_err_unexpected), 64'(e_err));
  endtask

  task automatic rsp_now();
    rsp_t r;
    r = rq.pop_front();
    i_tl_valid = 1'b1;
    i_tl_buy_price = r.bid - 32'd1;
    i_tl_sell_price = r.ask + 32'd1;
  endtask

  task automatic md(input int id, input int ask, input int bid, input logic [63:0] inv);
    i_md_valid = 1'b1; i_md_stock_id = 2'(id);
    i_md_best_ask = 32'(ask); i_md_best_bid = 32'(bid); i_md_inventory = inv;
  endtask

  task automatic step();
    if (auto_rsp && !i_tl_valid && rq.size() > 0 && rq[0].due <= cyc) rsp_now();
    @(posedge i_clk);
    model_step();
    #1;
    cyc++;
    check_all();
    if (o_tl_valid) issued.push_back(int'(o_tl_stock_id));
    i_md_valid = 1'b0;
    i_tl_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    chk("rst_tl_valid", 64'(o_tl_valid), 64'd0);
    chk("rst_tl_ask", 64'(o_tl_best_ask), 64'd0);
    chk("rst_tl_inv", o_tl_inventory, 64'd0);
    chk("rst_quote_valid", 64'(o_quote_valid), 64'd0);
    chk("rst_buy", 64'(o_buy_price), 64'd0);
    chk("rst_inflight", 64'(o_inflight), 64'd0);
    chk("rst_coalesce", 64'(o_coalesce_cnt), 64'd0);
    chk("rst_err", 64'(o_err_unexpected), 64'd0);
    model_reset();
    i_md_valid = 1'b0; i_tl_valid = 1'b0; i_enable = 1'b0; auto_rsp = 1'b0;
    issued.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    auto_rsp = 1'b1;
    while ((m_tags.size() > 0 || rq.size() > 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_inflight", 64'(o_inflight), 64'd0);
  endtask

  initial begin
    vt[0] = '{1, 2, 1005, 1000, 0, 0, 0,    0, 0, 0, 0,          0, 0, 0, 0,      0};
    vt[1] = '{0, 0, 0, 0,       0, 0, 0,    1, 2, 1005, 1000,    0, 0, 0, 0,      1};
    vt[2] = '{0, 0, 0, 0,       0, 0, 0,    0, 2, 1005, 1000,    0, 0, 0, 0,      1};
    vt[3] = vt[2];
    vt[4] = vt[2];
    vt[5] = vt[2];
    vt[6] = '{0, 0, 0, 0,       1, 999, 1006, 0, 2, 1005, 1000,  1, 2, 999, 1006, 0};
    vt[7] = '{0, 0, 0, 0,       0, 0, 0,    0, 2, 1005, 1000,    0, 2, 999, 1006, 0};

    #2;
    do_reset();

    // Directed single-update table: issue latency, response tagging, inflight return.
    i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].md_v != 0) md(vt[i].id, vt[i].ask, vt[i].bid, 64'd0);
      if (vt[i].tlv != 0) begin
        if (rq.size() > 0) void'(rq.pop_front());
        i_tl_valid = 1'b1; i_tl_buy_price = 32'(vt[i].buy); i_tl_sell_price = 32'(vt[i].sell);
      end
      step();
      chk("tbl_tl_valid", 64'(o_tl_valid), 64'(vt[i].e_tlv));
      chk("tbl_tl_id", 64'(o_tl_stock_id), 64'(vt[i].e_tlid));
      chk("tbl_tl_ask", 64'(o_tl_best_ask), 64'(vt[i].e_tlask));
      chk("tbl_tl_bid", 64'(o_tl_best_bid), 64'(vt[i].e_tlbid));
      chk("tbl_q_valid", 64'(o_quote_valid), 64'(vt[i].e_qv));
      chk("tbl_q_id", 64'(o_quote_stock_id), 64'(vt[i].e_qid));
      chk("tbl_buy", 64'(o_buy_price), 64'(vt[i].e_buy));
      chk("tbl_sell", 64'(o_sell_price), 64'(vt[i].e_sell));
      chk("tbl_inflight", 64'(o_inflight), 64'(vt[i].e_infl));
    end

    // Round-robin order, including resumption from the pointer.
    do_reset();
    auto_rsp = 1'b1;
    for (int s = 0; s < NS; s++) begin md(s, 50 + s, 40 + s, 64'(s)); step(); end
    i_enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    i_enable = 1'b0;
    md(0, 60, 55, 64'd7);
    step();
    i_enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rr_count", 64'(issued.size()), 64'd5);
    if (issued.size() == 5) begin
      chk("rr_0", 64'(issued[0]), 64'd0);
      chk("rr_1", 64'(issued[1]), 64'd1);
      chk("rr_2", 64'(issued[2]), 64'd2);
      chk("rr_3", 64'(issued[3]), 64'd3);
      chk("rr_4", 64'(issued[4]), 64'd0);
    end
    drain();

    // Coalescing while disabled.
    do_reset();
    md(1, 10, 5, 64'd1); step();
    md(1, 11, 5, 64'd2); step();
    md(1, 12, 5, 64'd3); step();
    chk("coal_cnt", 64'(o_coalesce_cnt), 64'd2);
    i_enable = 1'b1;
    step();
    chk("coal_issue_valid", 64'(o_tl_valid), 64'd1);
    chk("coal_issue_ask", 64'(o_tl_best_ask), 64'd12);
    step();
    chk("coal_single_issue", 64'(o_tl_valid), 64'd0);
    drain();

    // Inflight cap and full-FIFO behaviour.
    do_reset();
    i_enable = 1'b1;
    for (int c = 0; c < 10; c++) begin md(c % NS, 100 + c, 90 + c, 64'(c)); step(); end
    chk("full_inflight", 64'(o_inflight), 64'd8);
    chk("full_no_issue", 64'(o_tl_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_inflight", 64'(o_inflight), 64'd8);
      chk("full_hold_no_issue", 64'(o_tl_valid), 64'd0);
    end
    rsp_now(); step();
    chk("full_pop_inflight", 64'(o_inflight), 64'd7);
    chk("full_pop_no_issue", 64'(o_tl_valid), 64'd0);
    step();
    chk("full_refill_issue", 64'(o_tl_valid), 64'd1);
    chk("full_refill_inflight", 64'(o_inflight), 64'd8);
    rsp_now(); step();
    chk("full_pop2_inflight", 64'(o_inflight), 64'd7);
    rsp_now(); step();
    chk("same_edge_issue", 64'(o_tl_valid), 64'd1);
    chk("same_edge_inflight", 64'(o_inflight), 64'd7);
    drain();

    // Write to the stock on the edge it is granted.
    do_reset();
    md(0, 20, 19, 64'd0); step();
    i_enable = 1'b1;
    md(0, 21, 19, 64'd0); step();
    chk("grant_wr_issue", 64'(o_tl_valid), 64'd1);
    chk("grant_wr_old_ask", 64'(o_tl_best_ask), 64'd20);
    chk("grant_wr_coal", 64'(o_coalesce_cnt), 64'd0);
    step();
    chk("grant_wr_reissue", 64'(o_tl_valid), 64'd1);
    chk("grant_wr_new_ask", 64'(o_tl_best_ask), 64'd21);
    drain();

    // Response with nothing in flight.
    do_reset();
    i_enable = 1'b1;
    i_tl_valid = 1'b1; i_tl_buy_price = 32'd5; i_tl_sell_price = 32'd6;
    step();
    chk("unexp_no_quote", 64'(o_quote_valid), 64'd0);
    chk("unexp_err", 64'(o_err_unexpected), 64'd1);
    for (int i = 0; i < 3; i++) step();
    chk("unexp_err_sticky", 64'(o_err_unexpected), 64'd1);

    // Randomized traffic with periodic response hold-off, then a mid-traffic reset.
    do_reset();
    auto_rsp = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      i_enable = ($urandom_range(0, 9) != 0);
      auto_rsp = ((c % 200) < 170);
      if ($urandom_range(0, 1) == 1)
        md(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 100000)),
           int'($urandom_range(0, 100000)), {$urandom, $urandom});
      step();
    end
    do_reset();
    i_enable = 1'b1;
    auto_rsp = 1'b1;
    md(1, 300, 290, 64'd9); step();
    step();
    chk("post_rst_issue", 64'(o_tl_valid), 64'd1);
    chk("post_rst_id", 64'(o_tl_stock_id), 64'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
